// File: rtl/pbs_pkg.sv
// pbs_pkg: shared state encoding, move table and LFSR taps for the battle datapath
package pbs_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE   = 3'd0;
    localparam state_t SELECT = 3'd1;
    localparam state_t ROLL   = 3'd2;
    localparam state_t APPLY  = 3'd3;
    localparam state_t DONE   = 3'd4;
    // entry i holds move i; packed so index 0 is the rightmost nibble
    localparam logic [7:0][3:0] MOVE_DMG  = {4'd15, 4'd8, 4'd4, 4'd2, 4'd12, 4'd9, 4'd6, 4'd3};
    localparam logic [7:0][3:0] MOVE_ACCU = {4'd1, 4'd5, 4'd11, 4'd15, 4'd3, 4'd7, 4'd15, 4'd15};
    // right-shifting Galois form of x^16+x^14+x^13+x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/pbs_lfsr.sv
// pbs_lfsr: 16-bit Galois LFSR random source with enable
module pbs_lfsr
    import pbs_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);
    // an all-zero state would lock up, so a zero seed becomes 1
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // shift right, folding the outgoing bit back through the taps
    always_ff @(posedge clk)
        if (!rst) q <= INIT;
        else if (en) q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
endmodule

// File: rtl/pbs_battle_dp.sv
// pbs_battle_dp: resolves one attack per turn request with accuracy roll and saturating damage
module pbs_battle_dp
    import pbs_pkg::*;
#(
    parameter int          HP_W      = 4,
    parameter int          MOVE_W    = 2,
    parameter int          RNG_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              actr,
    input  logic [MOVE_W-1:0] p_move,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic              ko,
    output logic [MOVE_W-1:0] ai_move,
    output logic [HP_W-1:0]   dmg,
    output logic [RNG_W-1:0]  accu,
    output logic [HP_W-1:0]   p_hp,
    output logic [HP_W-1:0]   ai_hp
);
    state_t            state;
    logic              actr_q;
    logic [MOVE_W-1:0] pmove_q;
    logic [15:0]       lfsr;
    logic [MOVE_W-1:0] move;
    logic [2:0]        mi;
    logic [RNG_W-1:0]  roll;
    logic [HP_W-1:0]   tgt;
    logic [HP_W-1:0]   tgt_nxt;

    pbs_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (!stop),
        .q   (lfsr)
    );

    assign busy = state != IDLE;
    assign done = state == DONE;

    // move choice, roll and saturating damage on the current target
    always_comb begin
        move    = actr_q ? lfsr[MOVE_W-1:0] : pmove_q;
        mi      = 3'(move);
        roll    = lfsr[8+RNG_W-1:8];
        tgt     = actr_q ? p_hp : ai_hp;
        tgt_nxt = (dmg >= tgt) ? '0 : tgt - dmg;
    end

    // turn sequencing: select move, roll accuracy, apply damage, report
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            actr_q  <= 1'b0;
            pmove_q <= '0;
            hit     <= 1'b0;
            ko      <= 1'b0;
            ai_move <= '0;
            dmg     <= '0;
            accu    <= '0;
            p_hp    <= '1;
            ai_hp   <= '1;
        end else begin
            case (state)
                IDLE: if (start && !ko) begin
                    state   <= SELECT;
                    actr_q  <= actr;
                    pmove_q <= p_move;
                end
                SELECT: begin
                    dmg   <= HP_W'(MOVE_DMG[mi]);
                    accu  <= RNG_W'(MOVE_ACCU[mi]);
                    if (actr_q) ai_move <= move;
                    state <= ROLL;
                end
                ROLL: begin
                    hit   <= roll <= accu;
                    state <= APPLY;
                end
                APPLY: begin
                    if (hit && actr_q) p_hp <= tgt_nxt;
                    if (hit && !actr_q) ai_hp <= tgt_nxt;
                    state <= DONE;
                end
                DONE: begin
                    ko    <= (p_hp == '0) || (ai_hp == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pbs_battle_dp.sv
// tb_pbs_battle_dp: scoreboard bench for the battle datapath at default parameters
module tb_pbs_battle_dp;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       actr = 1'b0;
    logic       stop = 1'b1;
    logic [1:0] p_move = 2'd0;
    logic       busy, done, hit, ko;
    logic [1:0] ai_move;
    logic [3:0] dmg, accu, p_hp, ai_hp;

    pbs_battle_dp dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .actr    (actr),
        .p_move  (p_move),
        .stop    (stop),
        .busy    (busy),
        .done    (done),
        .hit     (hit),
        .ko      (ko),
        .ai_move (ai_move),
        .dmg     (dmg),
        .accu    (accu),
        .p_hp    (p_hp),
        .ai_hp   (ai_hp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic [3:0] dmg;
        logic [3:0] accu;
        logic [1:0] aim;
        logic [3:0] php;
        logic [3:0] aihp;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         n_done = 0;
    int         n_acc = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    int         m_cnt = 0;
    logic       m_ko = 1'b0;
    logic [3:0] m_p = 4'd15;
    logic [3:0] m_ai = 4'd15;
    logic [1:0] m_aim = 2'd0;
    int         dmg_t[4] = '{3, 6, 9, 12};
    int         accu_t[4] = '{15, 15, 7, 3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] sat(input logic [3:0] h, input logic [3:0] d);
        return (d >= h) ? 4'd0 : h - d;
    endfunction

    task automatic tick();
        logic [15:0] l1, l2;
        logic [1:0]  mv;
        exp_t        e;
        if (!rst) begin
            m_lfsr = 16'hACE1;
            m_cnt  = 0;
            m_ko   = 1'b0;
            m_p    = 4'd15;
            m_ai   = 4'd15;
            m_aim  = 2'd0;
            sbq.delete();
        end else begin
            if (m_cnt == 0) begin
                if (start && !m_ko) begin
                    l1     = stop ? m_lfsr : step(m_lfsr);
                    l2     = stop ? l1 : step(l1);
                    mv     = actr ? l1[1:0] : p_move;
                    e.dmg  = 4'(dmg_t[mv]);
                    e.accu = 4'(accu_t[mv]);
                    e.hit  = l2[11:8] <= e.accu;
                    if (actr) m_aim = mv;
                    if (e.hit && actr) m_p = sat(m_p, e.dmg);
                    if (e.hit && !actr) m_ai = sat(m_ai, e.dmg);
                    e.aim  = m_aim;
                    e.php  = m_p;
                    e.aihp = m_ai;
                    sbq.push_back(e);
                    n_acc++;
                    m_cnt = 1;
                end
            end else if (m_cnt == 4) begin
                m_cnt = 0;
                m_ko  = (m_p == 4'd0) || (m_ai == 4'd0);
            end else begin
                m_cnt++;
            end
            if (!stop) m_lfsr = step(m_lfsr);
        end
        @(posedge clk);
        #1;
        check("busy", busy, m_cnt != 0);
        check("done", done, m_cnt == 4);
        check("ko", ko, m_ko);
        if (done) begin
            n_done++;
            if (sbq.size() == 0) begin
                check("sb_empty", 0, 1);
            end else begin
                e = sbq.pop_front();
                check("sb_hit", hit, e.hit);
                check("sb_dmg", dmg, e.dmg);
                check("sb_accu", accu, e.accu);
                check("sb_ai_move", ai_move, e.aim);
                check("sb_p_hp", p_hp, e.php);
                check("sb_ai_hp", ai_hp, e.aihp);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // one start pulse, bounded wait for done, then one more cycle back to IDLE
    task automatic run_turn(input logic a, input logic [1:0] m, output int lat);
        actr   = a;
        p_move = m;
        start  = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
        if (!done) check("turn_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int         lat, d0;
        logic [3:0] pp, pa;
        tick();
        tick();
        rst = 1'b1;
        check("rst_p_hp", p_hp, 15);
        check("rst_ai_hp", ai_hp, 15);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ko", ko, 0);
        check("rst_dmg", dmg, 0);
        check("rst_accu", accu, 0);
        check("rst_hit", hit, 0);
        check("rst_ai_move", ai_move, 0);

        run_turn(1'b0, 2'd0, lat);
        check("t2_lat", lat, 4);
        check("t2_hit", hit, 1);
        check("t2_dmg", dmg, 3);
        check("t2_ai_hp", ai_hp, 12);
        check("t2_p_hp", p_hp, 15);

        run_turn(1'b0, 2'd3, lat);
        check("t3_hit", hit, 0);
        check("t3_accu", accu, 3);
        check("t3_ai_hp", ai_hp, 12);

        do_reset();
        run_turn(1'b1, 2'd0, lat);
        check("t4_ai_move", ai_move, 1);
        check("t4_dmg", dmg, 6);
        check("t4_hit", hit, 1);
        check("t4_p_hp1", p_hp, 9);
        run_turn(1'b1, 2'd0, lat);
        check("t4_p_hp2", p_hp, 3);
        run_turn(1'b1, 2'd0, lat);
        check("t4_p_hp3", p_hp, 0);
        check("t4_ko", ko, 1);
        d0    = n_done;
        start = 1'b1;
        repeat (8) tick();
        start = 1'b0;
        check("t4_ko_busy", busy, 0);
        check("t4_ko_nodone", n_done - d0, 0);

        do_reset();
        actr   = 1'b0;
        p_move = 2'd3;
        d0     = n_done;
        start  = 1'b1;
        repeat (20) tick();
        start = 1'b0;
        repeat (3) tick();
        check("t5_held_turns", n_done - d0, 4);
        d0    = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("t5_pulse_turns", n_done - d0, 1);

        run_turn(1'b0, 2'd0, lat);
        check("t6_pre_ai_hp", ai_hp, 12);
        p_move = 2'd0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        d0  = n_done;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t6_busy", busy, 0);
        check("t6_ai_hp", ai_hp, 15);
        repeat (6) tick();
        check("t6_nodone", n_done - d0, 0);
        check("t6_ai_hp_hold", ai_hp, 15);

        stop = 1'b0;
        n_acc  = 0;
        n_done = 0;
        for (int i = 0; i < 1000; i++) begin
            if (ko) do_reset();
            pp = p_hp;
            pa = ai_hp;
            run_turn(1'($urandom), 2'($urandom), lat);
            check("rnd_p_mono", p_hp <= pp, 1);
            check("rnd_ai_mono", ai_hp <= pa, 1);
        end
        check("rnd_done_count", n_done, n_acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
